// File: rtl/and_16_pkg.sv
// -----------------------------------------------------------------------------
// and_16_pkg
// Shared types and constants for the 16-bit bitwise AND unit.
//   AND16_WIDTH       data width of operands and result (fixed at 16)
//   and16_data_t      one 16-bit operand/result word
//   and16_result_t    result word plus its zero flag, carried as one payload
//   AND16_RESULT_RST  payload value presented while in reset (y=0, zero=1)
// -----------------------------------------------------------------------------
package and_16_pkg;

   localparam int AND16_WIDTH = 16;

   typedef logic [AND16_WIDTH-1:0] and16_data_t;

   typedef struct packed {
      and16_data_t data;
      logic        zero;
   } and16_result_t;

   localparam and16_result_t AND16_RESULT_RST = '{data: '0, zero: 1'b1};

endpackage

// File: rtl/and_16_skid.sv
// -----------------------------------------------------------------------------
// and_16_skid
// Generic two-entry valid/ready skid buffer. A main register drives the output;
// a skid register catches one extra item while the main register is stalled,
// so the upstream ready can be a plain register with no path from out_ready.
// Items leave strictly in acceptance order.
//
// Parameters
//   T        payload type
//   RST_VAL  payload value held in both registers after reset
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears all stored items)
//   in_valid   upstream offers in_data
//   in_ready   registered: buffer can accept this cycle (skid entry empty)
//   in_data    incoming payload
//   out_valid  out_data holds a valid item
//   out_ready  downstream takes out_data this cycle
//   out_data   outgoing payload (held while out_valid && !out_ready)
// -----------------------------------------------------------------------------
module and_16_skid #(
   parameter type T       = logic,
   parameter T    RST_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   T     main_p1, main_nxt;
   T     skid_p1, skid_nxt;
   logic vld_p1, vld_nxt;
   logic skid_vld_p1, skid_vld_nxt;
   logic rdy_q;
   logic acc;

   assign acc = in_valid && rdy_q;

   always_comb begin
      main_nxt     = main_p1;
      skid_nxt     = skid_p1;
      vld_nxt      = vld_p1;
      skid_vld_nxt = skid_vld_p1;
      if (!vld_p1 || out_ready) begin
         // Main is free or draining. The skid entry is older than anything
         // arriving now, so it moves first; an accept cannot coincide with a
         // full skid because in_ready is low then.
         if (skid_vld_p1) begin
            main_nxt     = skid_p1;
            vld_nxt      = 1'b1;
            skid_vld_nxt = 1'b0;
         end else if (acc) begin
            main_nxt = in_data;
            vld_nxt  = 1'b1;
         end else begin
            vld_nxt = 1'b0;
         end
      end else if (acc) begin
         skid_nxt     = in_data;
         skid_vld_nxt = 1'b1;
      end
   end

   // ---- output stage (p1) ----
   always_ff @(posedge clk) begin
      if (rst) begin
         main_p1     <= RST_VAL;
         skid_p1     <= RST_VAL;
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         main_p1     <= main_nxt;
         skid_p1     <= skid_nxt;
         vld_p1      <= vld_nxt;
         skid_vld_p1 <= skid_vld_nxt;
         rdy_q       <= !skid_vld_nxt;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_p1;
   assign out_data  = main_p1;

endmodule

// File: rtl/and_16.sv
// -----------------------------------------------------------------------------
// and_16
// Registered 16-bit bitwise AND leaf of the ALU: y = a & b, presented one cycle
// after acceptance through a valid/ready output stage with a two-entry skid
// buffer so full throughput is kept under backpressure.
//
// Build option
//   AND16_ZERO_FLAG_EN  when defined, adds y_zero (y == 0), registered with y
//                       and carried through the skid buffer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a/b carry a valid operand pair
//   in_ready   registered: unit can accept a pair this cycle
//   a, b       16-bit operands
//   out_valid  y holds a valid result
//   out_ready  downstream accepts y this cycle
//   y          result a & b
//   y_zero     y == 0 (only with AND16_ZERO_FLAG_EN)
// -----------------------------------------------------------------------------
module and_16
   import and_16_pkg::*;
#(
   parameter int WIDTH = AND16_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y
`ifdef AND16_ZERO_FLAG_EN
   ,
   output logic             y_zero
`endif
);

`ifdef AND16_ZERO_FLAG_EN
   and16_result_t res_p0;
   and16_result_t res_p1;

   // ---- compute stage (p0) ----
   always_comb begin
      res_p0.data = a & b;
      res_p0.zero = ~|(a & b);
   end

   and_16_skid #(
      .T       (and16_result_t),
      .RST_VAL (AND16_RESULT_RST)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (res_p0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (res_p1)
   );

   assign y      = res_p1.data;
   assign y_zero = res_p1.zero;
`else
   and16_data_t res_p0;
   and16_data_t res_p1;

   // ---- compute stage (p0) ----
   assign res_p0 = a & b;

   and_16_skid #(
      .T       (and16_data_t),
      .RST_VAL ('0)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (res_p0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (res_p1)
   );

   assign y = res_p1;
`endif

endmodule

// File: tb/tb_and_16.sv
module tb_and_16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
`ifdef AND16_ZERO_FLAG_EN
   logic        y_zero;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   and_16 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
`ifdef AND16_ZERO_FLAG_EN
      ,
      .y_zero    (y_zero)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; out_ready = 1'b1;
      step();
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (y !== 16'h0000) begin fails++; $display("FAIL reset_y got %h want 0000", y); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
`ifdef AND16_ZERO_FLAG_EN
      tests++; if (y_zero !== 1'b1) begin fails++; $display("FAIL reset_y_zero got %b want 1", y_zero); end
`endif
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL release_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_vectors();
      logic [15:0] va [5];
      logic [15:0] vb [5];
      logic [15:0] ve [5];
      va = '{16'h0000, 16'hFFFF, 16'hCCCC, 16'hFFFF, 16'h3CAF};
      vb = '{16'h0000, 16'h0000, 16'hAAAA, 16'hFFFF, 16'hC3AC};
      ve = '{16'h0000, 16'h0000, 16'h8888, 16'hFFFF, 16'h00AC};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a = va[i]; b = vb[i]; in_valid = 1'b1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL vec%0d_in_ready got %b want 1", i, in_ready); end
         step();
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL vec%0d_out_valid got %b want 1", i, out_valid); end
         tests++; if (y !== ve[i]) begin fails++; $display("FAIL vec%0d_y got %h want %h", i, y, ve[i]); end
      end
      in_valid = 1'b0;
      a = 16'h5555; b = 16'h5555;
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL vec_idle_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      a = 16'hCCCC; b = 16'hAAAA; in_valid = 1'b1;
      step();
      tests++; if (y !== 16'h8888 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_first got y=%h v=%b want 8888 1", y, out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
      a = 16'hFFFF; b = 16'hFFFF;
      step();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
      tests++; if (y !== 16'h8888) begin fails++; $display("FAIL bp_hold_y got %h want 8888", y); end
      // Offered while full: must be ignored.
      a = 16'h1234; b = 16'hFFFF;
      step();
      tests++; if (y !== 16'h8888 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall got y=%h r=%b want 8888 0", y, in_ready); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      tests++; if (y !== 16'hFFFF || out_valid !== 1'b1) begin fails++; $display("FAIL bp_second got y=%h v=%b want ffff 1", y, out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got %b want 1", in_ready); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [15:0] q [$];
      logic [15:0] exp;
      logic        rdy_before;
      int          accepted = 0;
      int          cycles = 0;
      int          guard = 0;
      while (accepted < 1000 && cycles < 20000) begin
         rdy_before = in_ready;
         in_valid  = 1'($urandom_range(0, 1));
         a         = 16'($urandom);
         b         = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         tests++; if (in_ready !== rdy_before) begin fails++; $display("FAIL st_ready_comb got %b want %b", in_ready, rdy_before); end
         tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL st_ready got %b want %b", in_ready, q.size() < 2); end
         tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL st_valid got %b want %b", out_valid, q.size() > 0); end
         if (out_valid && out_ready && q.size() > 0) begin
            exp = q.pop_front();
            tests++; if (y !== exp) begin fails++; $display("FAIL st_y got %h want %h", y, exp); end
         end
         if (in_valid && in_ready) begin
            q.push_back(a & b);
            accepted++;
         end
         step();
         cycles++;
      end
      tests++; if (accepted != 1000) begin fails++; $display("FAIL st_budget got %0d want 1000", accepted); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      while (q.size() > 0 && guard < 10) begin
         exp = q.pop_front();
         tests++; if (y !== exp || out_valid !== 1'b1) begin fails++; $display("FAIL st_drain got y=%h v=%b want %h 1", y, out_valid, exp); end
         step();
         guard++;
      end
      tests++; if (q.size() != 0) begin fails++; $display("FAIL st_drain_budget got %0d left want 0", q.size()); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL st_final_valid got %b want 0", out_valid); end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = 16'hF0F0; b = 16'hFF00;
      step();
      a = 16'h0FF0; b = 16'hFFFF;
      step();
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL mr_full got r=%b v=%b want 0 1", in_ready, out_valid); end
      rst = 1'b1;
      out_ready = 1'b1;
      a = 16'hFFFF; b = 16'hFFFF;
      step();
      tests++; if (out_valid !== 1'b0 || y !== 16'h0000) begin fails++; $display("FAIL mr_cleared got v=%b y=%h want 0 0000", out_valid, y); end
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mr_after1 got r=%b v=%b want 1 0", in_ready, out_valid); end
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mr_after2 got %b want 0", out_valid); end
   endtask

`ifdef AND16_ZERO_FLAG_EN
   task automatic test_zero_flag();
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 16'h0F0F; b = 16'hF0F0;
      step();
      tests++; if (y !== 16'h0000 || y_zero !== 1'b1) begin fails++; $display("FAIL zf_zero got y=%h z=%b want 0000 1", y, y_zero); end
      a = 16'h8001; b = 16'h8000;
      step();
      tests++; if (y !== 16'h8000 || y_zero !== 1'b0) begin fails++; $display("FAIL zf_nonzero got y=%h z=%b want 8000 0", y, y_zero); end
      in_valid = 1'b0;
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
`ifdef AND16_ZERO_FLAG_EN
      test_zero_flag();
`endif
      test_stream();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule
